// File: rtl/pair_list_packer_if.sv
// pair_list_packer_if: field stream in, packed pair_list_pair word out
interface pair_list_packer_if #(
  parameter int FIELD_W = 4,
  parameter int CNT_W   = 8
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [FIELD_W-1:0]   in_field;
  logic                 in_clear;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*FIELD_W-1:0] out_data;
  logic [CNT_W-1:0]     word_count;
  modport master (
    output in_valid, in_field, in_clear, out_ready,
    input  in_ready, out_valid, out_data, word_count
  );
  modport slave (
    input  in_valid, in_field, in_clear, out_ready,
    output in_ready, out_valid, out_data, word_count
  );
endinterface

// File: rtl/pair_list_packer.sv
// pair_list_packer: packs 8 serial fields into one registered pair_list_pair word
module pair_list_packer #(
  parameter int FIELD_W = 4,
  parameter int CNT_W   = 8
) (
  input logic clk,
  input logic rst,
  pair_list_packer_if.slave bus
);
  localparam int W = 8*FIELD_W;
  logic [2:0]   idx;
  logic [W-1:0] asm_r;
  logic         asm_full;
  logic         slot_free;
  logic         acc;
  logic         last;
  logic         load;
  logic [W-1:0] word;
  always_comb begin
    slot_free    = !bus.out_valid || bus.out_ready;
    bus.in_ready = !asm_full && !bus.in_clear;
    acc          = bus.in_valid && bus.in_ready;
    last         = acc && idx == 3'd7;
    load         = (last || asm_full) && slot_free;
    word         = asm_full ? asm_r : {bus.in_field, asm_r[W-FIELD_W-1:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx            <= '0;
      asm_r          <= '0;
      asm_full       <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.word_count <= '0;
    end else begin
      if (load) begin
        bus.out_data   <= word;
        bus.out_valid  <= 1'b1;
        bus.word_count <= bus.word_count + CNT_W'(1);
      end else if (bus.out_ready) begin
        bus.out_valid  <= 1'b0;
      end
      if (asm_full && slot_free) asm_full <= 1'b0;
      // a completed word parked in asm_r survives a clear
      if (bus.in_clear) begin
        idx <= '0;
        if (!asm_full) asm_r <= '0;
      end else if (acc) begin
        idx <= idx + 3'd1;
        if (!last) begin
          asm_r[idx*FIELD_W +: FIELD_W] <= bus.in_field;
        end else if (!slot_free) begin
          asm_r    <= word;
          asm_full <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pair_list_packer.sv
// tb_pair_list_packer: random and directed stimulus against a queue-based word model
module tb_pair_list_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pair_list_packer_if #(.FIELD_W(4), .CNT_W(8)) b ();
  pair_list_packer #(.FIELD_W(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(b));
  int checks = 0;
  int errors = 0;
  int fields[$];
  logic [31:0] expq[$];
  int completed = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] exp_wc();
    return 8'((completed - (expq.size() == 2 ? 1 : 0)) & 255);
  endfunction
  task automatic step(input logic v, input logic [3:0] f, input logic clr, input logic ordy);
    logic rdy;
    logic [31:0] w;
    @(negedge clk);
    b.in_valid = v;
    b.in_field = f;
    b.in_clear = clr;
    b.out_ready = ordy;
    #1;
    rdy = !clr && expq.size() < 2;
    check("in_ready", 32'(b.in_ready), 32'(rdy));
    check("out_valid", 32'(b.out_valid), 32'(expq.size() > 0));
    check("word_count", 32'(b.word_count), 32'(exp_wc()));
    if (expq.size() > 0) check("out_data", b.out_data, expq[0]);
    if (expq.size() > 0 && ordy) void'(expq.pop_front());
    if (clr) fields.delete();
    else if (v && rdy) begin
      fields.push_back(int'(f));
      if (fields.size() == 8) begin
        w = '0;
        for (int k = 0; k < 8; k++) w |= 32'(fields[k]) << (4*k);
        expq.push_back(w);
        completed++;
        fields.delete();
      end
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    b.in_valid = 1'b0;
    b.in_clear = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(b.out_valid), 32'd0);
    check("rst_out_data", b.out_data, 32'd0);
    check("rst_word_count", 32'(b.word_count), 32'd0);
    check("rst_in_ready", 32'(b.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    fields.delete();
    expq.delete();
    completed = 0;
  endtask
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask
  initial begin
    b.in_valid = 1'b0;
    b.in_field = '0;
    b.in_clear = 1'b0;
    b.out_ready = 1'b0;
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 4'(i), 1'b0, 1'b1);
    after_edge();
    check("t1_valid", 32'(b.out_valid), 32'd1);
    check("t1_data", b.out_data, 32'h87654321);
    check("t1_wc", 32'(b.word_count), 32'd1);
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    after_edge();
    check("t2_held", b.out_data, 32'h76543210);
    check("t2_full_ready", 32'(b.in_ready), 32'd0);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    after_edge();
    check("t2_data", b.out_data, 32'hFEDCBA98);
    check("t2_wc", 32'(b.word_count), 32'd2);
    check("t2_ready", 32'(b.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) step(1'b1, 4'(i), 1'b0, 1'b1);
    step(1'b1, 4'h7, 1'b1, 1'b1);
    for (int i = 9; i <= 16; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    after_edge();
    check("t3_data", b.out_data, 32'h0FEDCBA9);
    do_reset();
    for (int i = 0; i < 64; i++) step(1'b1, 4'($urandom), 1'b0, 1'b1);
    after_edge();
    check("t4_wc", 32'(b.word_count), 32'd8);
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 4'($urandom), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 4'(15 - i), 1'b0, 1'b1);
    after_edge();
    check("t5_data", b.out_data, 32'h89ABCDEF);
    do_reset();
    for (int i = 0; i < 2048; i++) step(1'b1, 4'($urandom), 1'b0, 1'b1);
    after_edge();
    check("t6_wrap", 32'(b.word_count), 32'd0);
    check("t6_valid", 32'(b.out_valid), 32'd1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 31) == 0,
           $urandom_range(0, 2) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
